// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the port arbiter and the backing memory.
// Handshake: a requester raises *_req/dm_rd/dm_wr and holds address/data until its stall drops;
// the arbiter holds mem_en/mem_addr/mem_wdata until mem_ready, then the memory answers with a one-cycle mem_done.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          fetch_stall;
  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          mem_stall;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          rw_err;

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
    input  mem_ready, mem_rdata, mem_done,
    output if_rdata, fetch_stall, dm_rdata, mem_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata, rw_err
  );

  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
    output mem_ready, mem_rdata, mem_done,
    input  if_rdata, fetch_stall, dm_rdata, mem_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata, rw_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported multi-cycle memory between the fetch and data ports and
// produces the fetch/mem stall signals; data wins unless fetch has waited STARVE_LIMIT grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int AW           = 16,
  parameter int DW           = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic [2:0]        o_dbg_state,
  output logic [7:0]        o_dbg_streak
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE_IF = 3'd1;
  localparam logic [2:0] WAIT_IF  = 3'd2;
  localparam logic [2:0] ISSUE_DM = 3'd3;
  localparam logic [2:0] WAIT_DM  = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [SW-1:0] r_streak;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;
  logic          r_rw_err;

  logic w_dm_req;
  logic w_grant_if;
  logic w_grant_dm;
  logic w_if_done;
  logic w_dm_done;

  assign w_dm_req   = bus.dm_rd | bus.dm_wr;
  assign w_grant_if = (r_state == IDLE) & bus.if_req & (~w_dm_req | (r_streak == STREAK_MAX));
  assign w_grant_dm = (r_state == IDLE) & w_dm_req & ~w_grant_if;
  assign w_if_done  = (r_state == WAIT_IF) & bus.mem_done;
  assign w_dm_done  = (r_state == WAIT_DM) & bus.mem_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_if)      w_next = ISSUE_IF;
        else if (w_grant_dm) w_next = ISSUE_DM;
      end
      ISSUE_IF: if (bus.mem_ready) w_next = WAIT_IF;
      WAIT_IF:  if (bus.mem_done)  w_next = IDLE;
      ISSUE_DM: if (bus.mem_ready) w_next = WAIT_DM;
      WAIT_DM:  if (bus.mem_done)  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_streak   <= '0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_rw_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (bus.dm_rd && bus.dm_wr) r_rw_err <= 1'b1;
      if (w_grant_if) begin
        r_addr   <= bus.if_addr;
        r_wr     <= 1'b0;
        r_streak <= '0;
      end else if (w_grant_dm) begin
        // Both rd and wr high is treated as a write.
        r_addr  <= bus.dm_addr;
        r_wdata <= bus.dm_wdata;
        r_wr    <= bus.dm_wr;
        if (bus.if_req && (r_streak != STREAK_MAX)) r_streak <= r_streak + 1'b1;
      end
      if (w_if_done)            r_if_rdata <= bus.mem_rdata;
      if (w_dm_done && !r_wr)   r_dm_rdata <= bus.mem_rdata;
    end
  end

  assign bus.mem_en    = (r_state == ISSUE_IF) | (r_state == ISSUE_DM);
  assign bus.mem_wr    = (r_state == ISSUE_DM) & r_wr;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.rw_err    = r_rw_err;

  // Completion releases the pipeline in the same cycle, so data bypasses the holding register.
  assign bus.fetch_stall = bus.if_req & ~w_if_done;
  assign bus.mem_stall   = w_dm_req & ~w_dm_done;
  assign bus.if_rdata    = w_if_done ? bus.mem_rdata : r_if_rdata;
  assign bus.dm_rdata    = (w_dm_done && !r_wr) ? bus.mem_rdata : r_dm_rdata;

  assign o_dbg_state  = r_state;
  assign o_dbg_streak = 8'(r_streak);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed arbitration/reset sequences and a
// randomized run against a transaction-level memory and arbitration model.
module tb_mem_port_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LIM = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  logic [7:0] dbg_streak;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.STARVE_LIMIT(LIM), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .o_dbg_state  (dbg_state),
    .o_dbg_streak (dbg_streak)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // memory model state
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pend_rdata;
  int            pend      = 0;
  int            ready_cnt = 0;
  int            lat_cfg   = 1;
  bit            model_on  = 1'b1;
  bit            rand_mem  = 1'b0;

  typedef struct {
    logic          is_if;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            rwait;
    int            lat;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 16'h5A3C;
  endfunction

  // Advance to the next negedge, answer the memory side for that cycle, let outputs settle.
  task automatic step();
    @(negedge clk);
    if (model_on) begin
      bus.mem_done  = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'($urandom);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.mem_done  = 1'b1;
          bus.mem_rdata = pend_rdata;
        end
      end else if (bus.mem_en) begin
        if (ready_cnt > 0) ready_cnt--;
        else begin
          bus.mem_ready = 1'b1;
          pend      = rand_mem ? int'($urandom_range(4, 1)) : lat_cfg;
          ready_cnt = rand_mem ? int'($urandom_range(2, 0)) : 0;
          if (bus.mem_wr) begin
            mem_arr[bus.mem_addr] = bus.mem_wdata;
            pend_rdata = 16'hDEAD;
          end else begin
            pend_rdata = mem_val(bus.mem_addr);
            exp_q.push_back(pend_rdata);
          end
        end
      end
    end
    #1;
  endtask

  task automatic run_until_release(input bit use_if, input string name);
    int n;
    n = 0;
    while ((use_if ? bus.fetch_stall : bus.mem_stall) && n < 50) begin
      step();
      n++;
    end
    check({name, " release"}, 32'(n < 50), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.if_req = 1'b0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_done = 1'b0;
    pend = 0; ready_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    int            stall_n, en_n, bad, n, gi;
    bit            prev_en, g_if, g_dm, exp_dm, in_dm, in_wr;
    int            m_streak;
    logic [4:0]    order;
    logic [DW-1:0] e;
    vec_t          v;

    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_rd = 1'b0; bus.dm_wr = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.mem_done = 1'b0;

    mem_arr[16'h0010] = 16'hABCD;
    mem_arr[16'h0020] = 16'h1234;
    mem_arr[16'hFFFF] = 16'h8001;
    //          is_if rd    wr    addr      wdata     rw lat exp_rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 0, 3, 16'hABCD};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1, 1, 16'h1234};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0300, 16'h5A5A, 2, 2, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0300, 16'h0000, 0, 2, 16'h5A5A};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 3, 4, 16'h8001};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 0, 1, 16'h5A5A};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1, 16'hFFFF};

    // reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst state", 32'(dbg_state), 32'd0);
    check("rst streak", 32'(dbg_streak), 32'd0);
    check("rst mem_en", 32'(bus.mem_en), 32'd0);
    check("rst mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst if_rdata", 32'(bus.if_rdata), 32'd0);
    check("rst dm_rdata", 32'(bus.dm_rdata), 32'd0);
    check("rst rw_err", 32'(bus.rw_err), 32'd0);
    rst = 1'b1;
    step();

    // single-transaction vector table
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      ready_cnt = v.rwait;
      lat_cfg   = v.lat;
      if (v.is_if) begin
        bus.if_addr = v.addr; bus.if_req = 1'b1;
      end else begin
        bus.dm_addr = v.addr; bus.dm_wdata = v.wdata; bus.dm_rd = v.rd; bus.dm_wr = v.wr;
      end
      #1;
      stall_n = 0; en_n = 0; bad = 0; n = 0;
      while ((v.is_if ? bus.fetch_stall : bus.mem_stall) && n < 50) begin
        stall_n++;
        if (bus.mem_en) begin
          en_n++;
          if (bus.mem_addr !== v.addr || bus.mem_wr !== v.wr || (v.wr && bus.mem_wdata !== v.wdata)) bad++;
        end
        step();
        n++;
      end
      check($sformatf("vec%0d stall cycles", i), 32'(stall_n), 32'(v.rwait + v.lat + 1));
      check($sformatf("vec%0d mem_en cycles", i), 32'(en_n), 32'(v.rwait + 1));
      check($sformatf("vec%0d issue fields", i), 32'(bad), 32'd0);
      check($sformatf("vec%0d rdata at done", i), 32'(v.is_if ? bus.if_rdata : bus.dm_rdata), 32'(v.exp_rdata));
      bus.if_req = 1'b0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
      step();
      check($sformatf("vec%0d rdata held", i), 32'(v.is_if ? bus.if_rdata : bus.dm_rdata), 32'(v.exp_rdata));
      check($sformatf("vec%0d back to idle", i), 32'(dbg_state), 32'd0);
    end

    // simultaneous fetch and data read: data first, one idle cycle, then fetch
    lat_cfg = 2; ready_cnt = 0;
    bus.if_addr = 16'h0040; bus.if_req = 1'b1;
    bus.dm_addr = 16'h0200; bus.dm_rd = 1'b1;
    step();
    check("A dm first en", 32'(bus.mem_en), 32'd1);
    check("A dm first addr", 32'(bus.mem_addr), 32'h0200);
    run_until_release(1'b0, "A dm");
    check("A fetch held", 32'(bus.fetch_stall), 32'd1);
    bus.dm_rd = 1'b0;
    step();
    check("A idle gap en", 32'(bus.mem_en), 32'd0);
    check("A idle gap fetch_stall", 32'(bus.fetch_stall), 32'd1);
    step();
    check("A if issue en", 32'(bus.mem_en), 32'd1);
    check("A if issue addr", 32'(bus.mem_addr), 32'h0040);
    run_until_release(1'b1, "A if");
    check("A if_rdata", 32'(bus.if_rdata), 32'(mem_val(16'h0040)));
    bus.if_req = 1'b0;
    step();

    // starvation limit: DM, DM, DM, IF, DM
    lat_cfg = 1; ready_cnt = 0;
    order = 5'b01000;
    bus.if_addr = 16'h0050; bus.if_req = 1'b1;
    bus.dm_addr = 16'h0100; bus.dm_rd = 1'b1;
    gi = 0; prev_en = bus.mem_en;
    for (int c = 0; c < 200 && gi < 5; c++) begin
      step();
      if (bus.mem_en && !prev_en) begin
        check($sformatf("B grant%0d is_if", gi), 32'(bus.mem_addr == 16'h0050), 32'(order[gi]));
        if (gi == 2) check("B streak saturated", 32'(dbg_streak), 32'd3);
        if (gi == 3) check("B streak cleared", 32'(dbg_streak), 32'd0);
        gi++;
      end
      prev_en = bus.mem_en;
      if (!bus.mem_stall) bus.dm_addr = bus.dm_addr + 16'd1;
    end
    check("B grant count", 32'(gi), 32'd5);
    run_until_release(1'b0, "B drain dm");
    bus.dm_rd = 1'b0;
    run_until_release(1'b1, "B drain if");
    bus.if_req = 1'b0;
    step();

    // rd and wr together: issued as a write, sticky error
    check("C rw_err before", 32'(bus.rw_err), 32'd0);
    bus.dm_addr = 16'h0310; bus.dm_wdata = 16'h1111; bus.dm_rd = 1'b1; bus.dm_wr = 1'b1;
    step();
    check("C mem_wr", 32'(bus.mem_wr), 32'd1);
    check("C mem_wdata", 32'(bus.mem_wdata), 32'h1111);
    check("C rw_err set", 32'(bus.rw_err), 32'd1);
    run_until_release(1'b0, "C");
    bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
    repeat (2) step();
    check("C rw_err sticky", 32'(bus.rw_err), 32'd1);

    // reset during WAIT_DM, then a stray mem_done
    lat_cfg = 10; ready_cnt = 0;
    bus.dm_addr = 16'h0400; bus.dm_rd = 1'b1;
    n = 0;
    while (dbg_state != 3'd4 && n < 20) begin step(); n++; end
    check("D reached wait", 32'(n < 20), 32'd1);
    step();
    rst = 1'b0;
    #1;
    check("D rst state", 32'(dbg_state), 32'd0);
    check("D rst mem_en", 32'(bus.mem_en), 32'd0);
    check("D rst mem_addr", 32'(bus.mem_addr), 32'd0);
    check("D rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("D rst if_rdata", 32'(bus.if_rdata), 32'd0);
    check("D rst dm_rdata", 32'(bus.dm_rdata), 32'd0);
    check("D rst rw_err", 32'(bus.rw_err), 32'd0);
    bus.dm_rd = 1'b0; model_on = 1'b0; pend = 0;
    bus.mem_ready = 1'b0; bus.mem_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    bus.mem_done = 1'b1; bus.mem_rdata = 16'hBEEF; bus.dm_rd = 1'b1;
    #1;
    check("D stray done idle stall", 32'(bus.mem_stall), 32'd1);
    check("D stray done idle rdata", 32'(bus.dm_rdata), 32'd0);
    step();
    check("D stray done issue state", 32'(dbg_state), 32'd3);
    check("D stray done issue stall", 32'(bus.mem_stall), 32'd1);
    check("D stray done issue rdata", 32'(bus.dm_rdata), 32'd0);
    bus.mem_done = 1'b0;
    model_on = 1'b1; lat_cfg = 2; ready_cnt = 0;
    run_until_release(1'b0, "D recover");
    check("D recover rdata", 32'(bus.dm_rdata), 32'(mem_val(16'h0400)));
    bus.dm_rd = 1'b0;
    step();

    // randomized traffic against the transaction model
    do_reset();
    exp_q.delete();
    rand_mem = 1'b1;
    m_streak = 0; in_dm = 1'b0; in_wr = 1'b0; prev_en = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      g_if = bus.if_req;
      g_dm = bus.dm_rd | bus.dm_wr;
      step();
      if (bus.mem_en && !prev_en) begin
        exp_dm = g_dm && !(g_if && m_streak == LIM);
        if (exp_dm) begin
          check("R dm grant addr", 32'(bus.mem_addr), 32'(bus.dm_addr));
          check("R dm grant wr", 32'(bus.mem_wr), 32'(bus.dm_wr));
          if (bus.dm_wr) check("R dm grant wdata", 32'(bus.mem_wdata), 32'(bus.dm_wdata));
          if (g_if && m_streak < LIM) m_streak++;
        end else begin
          check("R if grant addr", 32'(bus.mem_addr), 32'(bus.if_addr));
          check("R if grant wr", 32'(bus.mem_wr), 32'd0);
          m_streak = 0;
        end
        in_dm = exp_dm;
        in_wr = exp_dm && bus.dm_wr;
      end
      prev_en = bus.mem_en;
      check("R fetch_stall", 32'(bus.fetch_stall), 32'(bus.if_req && !(bus.mem_done && !in_dm)));
      check("R mem_stall", 32'(bus.mem_stall), 32'((bus.dm_rd | bus.dm_wr) && !(bus.mem_done && in_dm)));
      if (bus.mem_done && !in_wr) begin
        if (exp_q.size() == 0) check("R read queue", 32'd0, 32'd1);
        else begin
          e = exp_q.pop_front();
          check(in_dm ? "R dm_rdata" : "R if_rdata", 32'(in_dm ? bus.dm_rdata : bus.if_rdata), 32'(e));
        end
      end
      if (bus.if_req && !bus.fetch_stall) bus.if_req = 1'b0;
      else if (!bus.if_req && $urandom_range(2, 0) == 0) begin
        bus.if_addr = 16'($urandom);
        bus.if_req  = 1'b1;
      end
      if ((bus.dm_rd | bus.dm_wr) && !bus.mem_stall) begin
        bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
      end else if (!(bus.dm_rd | bus.dm_wr) && $urandom_range(2, 0) == 0) begin
        bus.dm_addr  = 16'($urandom_range(15, 0));
        bus.dm_wdata = 16'($urandom);
        bus.dm_wr    = 1'($urandom_range(1, 0));
        bus.dm_rd    = ~bus.dm_wr;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
